i2s_receiver: RTL and testbench

//  Receiving end of the I2S link driven by i2s_controller. Oversamples bit_clk, frame_clk
//  and data on the system clock, deserialises Philips-format frames (MSB first, WS low =

---
 rtl/i2s_receiver.sv | 164 ++++++++++++++++
 tb/tb_i2s_receiver.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_receiver.sv
// Philips-format I2S receiver: oversamples the serial link on the system clock and
// presents each complete left/right pair as parallel words with a one-cycle strobe.
module i2s_receiver #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_clk,
  input  logic             frame_clk,
  input  logic             data,
  output logic [WIDTH-1:0] sample_left,
  output logic [WIDTH-1:0] sample_right,
  output logic             sample_valid,
  output logic             frame_error
);

  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic {SYNC, RECV} state_t;

  state_t r_state;
  state_t w_nextState;

  logic r_bckMeta, r_bckSync, r_bckDly;
  logic r_wsMeta, r_wsSync, r_wsPrev;
  logic r_dataMeta, r_dataSync;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_leftHold;
  logic [WIDTH-1:0] r_pendRight;
  logic             r_leftOk;
  logic             r_aligned;
  logic             r_pairPend;
  logic             r_errPend;

  logic             w_rise;
  logic             w_wsChange;
  logic             w_resync;
  logic             w_shiftBit;
  logic             w_slotEnd;
  logic [CW-1:0]    w_total;
  logic [WIDTH-1:0] w_shiftIn;
  logic [WIDTH-1:0] w_word;

  assign w_rise     = r_bckSync & ~r_bckDly;
  assign w_wsChange = r_wsSync ^ r_wsPrev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SYNC;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (r_state == SYNC && w_rise && w_wsChange) begin
      w_nextState = RECV;
    end
  end

  always_comb begin
    w_resync   = 1'b0;
    w_shiftBit = 1'b0;
    w_slotEnd  = 1'b0;
    if (w_rise) begin
      if (r_state == SYNC) begin
        w_resync = w_wsChange;
      end else begin
        w_shiftBit = ~w_wsChange;
        w_slotEnd  = w_wsChange;
      end
    end
  end

  // The bit taken on a WS change is the LSB of the slot that just ended; short slots
  // are left-justified with zero padding, long ones keep only their first WIDTH bits.
  always_comb begin
    w_total   = (r_cnt == CW'(WIDTH + 1)) ? r_cnt : r_cnt + CW'(1);
    w_shiftIn = (r_cnt < CW'(WIDTH)) ? {r_shift[WIDTH-2:0], r_dataSync} : r_shift;
    w_word    = w_shiftIn;
    if (w_total < CW'(WIDTH)) begin
      w_word = w_shiftIn << (CW'(WIDTH) - w_total);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bckMeta   <= 1'b0;
      r_bckSync   <= 1'b0;
      r_bckDly    <= 1'b0;
      r_wsMeta    <= 1'b0;
      r_wsSync    <= 1'b0;
      r_wsPrev    <= 1'b0;
      r_dataMeta  <= 1'b0;
      r_dataSync  <= 1'b0;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_leftHold  <= '0;
      r_pendRight <= '0;
      r_leftOk    <= 1'b0;
      r_aligned   <= 1'b0;
      r_pairPend  <= 1'b0;
      r_errPend   <= 1'b0;
    end else begin
      r_bckMeta  <= bit_clk;
      r_bckSync  <= r_bckMeta;
      r_bckDly   <= r_bckSync;
      r_wsMeta   <= frame_clk;
      r_wsSync   <= r_wsMeta;
      r_dataMeta <= data;
      r_dataSync <= r_dataMeta;
      r_pairPend <= 1'b0;
      r_errPend  <= 1'b0;
      if (w_rise) begin
        r_wsPrev <= r_wsSync;
      end
      if (w_resync) begin
        r_cnt     <= '0;
        r_shift   <= '0;
        r_leftOk  <= 1'b0;
        r_aligned <= 1'b0;
      end
      if (w_shiftBit) begin
        r_shift <= w_shiftIn;
        r_cnt   <= w_total;
      end
      // The slot entered at sync time is partial by construction, so its length is not reported.
      if (w_slotEnd) begin
        r_cnt     <= '0;
        r_shift   <= '0;
        r_aligned <= 1'b1;
        r_errPend <= r_aligned & (w_total != CW'(WIDTH));
        if (!r_wsPrev) begin
          r_leftHold <= w_word;
          r_leftOk   <= 1'b1;
        end else begin
          r_pairPend  <= r_leftOk;
          r_pendRight <= w_word;
          r_leftOk    <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_left  <= '0;
      sample_right <= '0;
      sample_valid <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      sample_valid <= r_pairPend;
      frame_error  <= r_errPend;
      if (r_pairPend) begin
        sample_left  <= r_leftHold;
        sample_right <= r_pendRight;
      end
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// Bench for i2s_receiver: drives I2S slots at clk/8 and compares captured pairs and
// error pulses against a slot-segmentation model of the received bit stream.
module tb_i2s_receiver;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             bit_clk = 1'b0;
  logic             frame_clk = 1'b0;
  logic             data = 1'b0;
  logic [WIDTH-1:0] sample_left;
  logic [WIDTH-1:0] sample_right;
  logic             sample_valid;
  logic             frame_error;

  int errors = 0;
  int checks = 0;

  logic             txWs[$];
  logic             txData[$];
  logic             pendWs[$];
  logic             pendD[$];
  int               slotCh[$];
  int               slotLen[$];
  logic [31:0]      slotWord[$];
  logic [WIDTH-1:0] obsL[$];
  logic [WIDTH-1:0] obsR[$];
  logic [WIDTH-1:0] expL[$];
  logic [WIDTH-1:0] expR[$];
  int               obsErr = 0;
  int               expErr = 0;
  int               backToBack = 0;
  logic             prevValid = 1'b0;

  always #5 clk = ~clk;

  i2s_receiver #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .bit_clk      (bit_clk),
    .frame_clk    (frame_clk),
    .data         (data),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .frame_error  (frame_error)
  );

  always @(negedge clk) begin
    if (!reset) begin
      if (sample_valid) begin
        obsL.push_back(sample_left);
        obsR.push_back(sample_right);
      end
      if (frame_error) obsErr++;
      if (sample_valid && prevValid) backToBack++;
      prevValid = sample_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic sendBit(input logic ws, input logic d);
    bit_clk   = 1'b0;
    frame_clk = ws;
    data      = d;
    txWs.push_back(ws);
    txData.push_back(d);
    tick(4);
    bit_clk = 1'b1;
    tick(4);
  endtask

  task automatic addSlot(input int ch, input int len, input logic [31:0] word);
    slotCh.push_back(ch);
    slotLen.push_back(len);
    slotWord.push_back(word);
  endtask

  task automatic addFrame(input logic [31:0] l, input int lenL, input logic [31:0] r, input int lenR);
    addSlot(0, lenL, l);
    addSlot(1, lenR, r);
  endtask

  // Philips timing: WS switches one bit early, so each slot's LSB carries the next WS.
  task automatic buildBits();
    pendWs.delete();
    pendD.delete();
    for (int s = 0; s < slotCh.size(); s++) begin
      for (int i = 0; i < slotLen[s]; i++) begin
        pendD.push_back(slotWord[s][slotLen[s]-1-i]);
        pendWs.push_back((i == slotLen[s] - 1) ? logic'(slotCh[s] == 0) : logic'(slotCh[s] == 1));
      end
    end
    slotCh.delete();
    slotLen.delete();
    slotWord.delete();
  endtask

  task automatic sendBits(input int from, input int upTo);
    for (int k = from; k < upTo; k++) sendBit(pendWs[k], pendD[k]);
  endtask

  task automatic applyStimulus(input int skip);
    buildBits();
    sendBits(skip, pendWs.size());
    tick(12);
  endtask

  task automatic resetDut();
    bit_clk = 1'b0;
    tick(4);
    reset = 1'b1;
    txWs.delete();
    txData.delete();
    obsL.delete();
    obsR.delete();
    obsErr = 0;
    prevValid = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(2);
  endtask

  // Reference: split the received stream at WS changes; the first change only establishes
  // alignment, every later one closes a slot whose bits run up to and including that rise.
  task automatic runModel();
    logic             prev;
    logic             synced;
    logic             aligned;
    logic             leftOk;
    logic [WIDTH-1:0] leftWord;
    logic [WIDTH-1:0] word;
    int               start;
    int               cnt;
    expL.delete();
    expR.delete();
    expErr   = 0;
    prev     = 1'b0;
    synced   = 1'b0;
    aligned  = 1'b0;
    leftOk   = 1'b0;
    leftWord = '0;
    start    = 0;
    for (int k = 0; k < txWs.size(); k++) begin
      if (txWs[k] !== prev) begin
        if (synced) begin
          cnt  = k - start;
          word = '0;
          for (int i = 0; i < WIDTH && i < cnt; i++) word[WIDTH-1-i] = txData[start+1+i];
          if (aligned && cnt != WIDTH) expErr++;
          if (prev == 1'b0) begin
            leftWord = word;
            leftOk   = 1'b1;
          end else begin
            if (leftOk) begin
              expL.push_back(leftWord);
              expR.push_back(word);
            end
            leftOk = 1'b0;
          end
          aligned = 1'b1;
        end else begin
          synced  = 1'b1;
          aligned = 1'b0;
          leftOk  = 1'b0;
        end
        start = k;
        prev  = txWs[k];
      end
    end
  endtask

  task automatic checkSession(input string tag);
    int n;
    runModel();
    checkOutput($sformatf("%s_pulses", tag), obsL.size(), expL.size());
    n = (obsL.size() < expL.size()) ? obsL.size() : expL.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_left%0d", tag, i), obsL[i], expL[i]);
      checkOutput($sformatf("%s_right%0d", tag, i), obsR[i], expR[i]);
    end
    checkOutput($sformatf("%s_errors", tag), obsErr, expErr);
  endtask

  function automatic logic [31:0] obsAt(input int i, input logic isLeft);
    if (i >= obsL.size()) return 32'hxxxx_xxxx;
    return isLeft ? 32'(obsL[i]) : 32'(obsR[i]);
  endfunction

  initial begin
    logic [31:0] r18;
    int          len;
    int          lastIdx;
    $display("[TB] starting i2s_receiver bench");

    resetDut();
    checkOutput("rst_left", sample_left, 0);
    checkOutput("rst_right", sample_right, 0);
    checkOutput("rst_valid", sample_valid, 0);
    checkOutput("rst_error", frame_error, 0);

    for (int f = 0; f < 3; f++) addFrame(17, 16, 17, 16);
    applyStimulus(0);
    checkSession("s1");
    checkOutput("s1_first_left17", obsAt(0, 1'b1), 17);
    checkOutput("s1_first_right17", obsAt(0, 1'b0), 17);

    resetDut();
    addFrame($urandom, 16, $urandom, 16);
    addFrame(32'hA5C3, 16, 32'h5A3C, 16);
    addFrame(32'h8001, 16, 32'h7FFE, 16);
    applyStimulus(0);
    checkSession("s2");
    checkOutput("s2_second_left", obsAt(1, 1'b1), 32'h8001);

    resetDut();
    for (int f = 0; f < 3; f++) addFrame($urandom, 16, $urandom, 16);
    applyStimulus(3);
    checkSession("s3a");

    resetDut();
    addSlot(1, 16, $urandom);
    for (int f = 0; f < 2; f++) addFrame($urandom, 16, $urandom, 16);
    applyStimulus(0);
    checkSession("s3b");

    resetDut();
    r18 = $urandom & 32'h3FFFF;
    addFrame($urandom, 16, $urandom, 16);
    addFrame($urandom, 16, $urandom, 16);
    addFrame(32'hABC, 12, $urandom, 16);
    addFrame($urandom, 16, $urandom, 16);
    addFrame(r18, 18, $urandom, 16);
    addFrame($urandom, 16, $urandom, 16);
    applyStimulus(0);
    checkSession("s4");
    checkOutput("s4_short_left", obsAt(1, 1'b1), 32'hABC0);
    checkOutput("s4_long_left", obsAt(3, 1'b1), r18[17:2]);

    resetDut();
    for (int f = 0; f < 4; f++) addFrame($urandom, 16, $urandom, 16);
    buildBits();
    sendBits(0, 88);
    tick(12);
    checkSession("s5a");
    resetDut();
    checkOutput("s5_rst_left", sample_left, 0);
    checkOutput("s5_rst_right", sample_right, 0);
    checkOutput("s5_rst_valid", sample_valid, 0);
    sendBits(88, pendWs.size());
    tick(12);
    checkSession("s5b");

    for (int t = 0; t < 20; t++) begin
      frame_clk = ~frame_clk;
      tick(50);
    end
    runModel();
    lastIdx = expL.size() - 1;
    checkOutput("s6_pulses", obsL.size(), expL.size());
    checkOutput("s6_errors", obsErr, expErr);
    checkOutput("s6_hold_left", sample_left, (lastIdx >= 0) ? 32'(expL[lastIdx]) : 32'hxxxx_xxxx);
    checkOutput("s6_hold_right", sample_right, (lastIdx >= 0) ? 32'(expR[lastIdx]) : 32'hxxxx_xxxx);

    resetDut();
    for (int f = 0; f < 6; f++) begin
      len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(14, 18)) : 16;
      addFrame($urandom, len, $urandom, 16);
    end
    applyStimulus(0);
    checkSession("s7");

    checkOutput("no_back_to_back", backToBack, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
